// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and the x0 index for the register-file writeback slice.
package regfile_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; last_q records the most recent winner.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic last_q, last_d;
    always_comb gnt = (&req) ? (last_q ? 2'b01 : 2'b10) : req;
    always_comb last_d = advance ? gnt[1] : last_q;
    // Reset to source 1 so source 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU/LSU writebacks onto the register-file write port
// and tracks in-flight destinations for RAW hazard detection.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid_i,
    input  logic [ADDR_WIDTH-1:0] req0_rd_i,
    input  logic [DATA_WIDTH-1:0] req0_data_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [ADDR_WIDTH-1:0] req1_rd_i,
    input  logic [DATA_WIDTH-1:0] req1_data_i,
    output logic                  req1_ready_o,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_i,
    input  logic [ADDR_WIDTH-1:0] RS1_ADDR_i,
    input  logic [ADDR_WIDTH-1:0] RS2_ADDR_i,
    output logic                  hazard_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] RD_ADDR_o,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic [1:0]            gnt;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid_i, req0_valid_i}),
        .advance (req0_valid_i | req1_valid_i),
        .gnt     (gnt)
    );

    assign req0_ready_o = gnt[0];
    assign req1_ready_o = gnt[1];
    assign xfer         = |gnt;
    assign sel_rd       = gnt[1] ? req1_rd_i : req0_rd_i;
    assign sel_data     = gnt[1] ? req1_data_i : req0_data_i;

    // Writes to x0 are accepted but never reach the register file.
    assign wr_en_d = xfer && (sel_rd != REG_ZERO);
    assign rd_d    = xfer ? sel_rd : rd_q;
    assign data_d  = xfer ? sel_data : data_q;

    // Set is applied after clear so a newer producer keeps ownership.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_q) pending_d[rd_q] = 1'b0;
        if (issue_valid_i && issue_rd_i != REG_ZERO) pending_d[issue_rd_i] = 1'b1;
        pending_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            pending_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end

    assign hazard_o  = pending_q[RS1_ADDR_i] | pending_q[RS2_ADDR_i];
    assign wr_en_o   = wr_en_q;
    assign RD_ADDR_o = rd_q;
    assign data_o    = data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of arbitration, output register, x0 discard and scoreboard.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0, issue_valid_i = 1'b0;
    logic [4:0]  req0_rd_i = '0, req1_rd_i = '0, issue_rd_i = '0, RS1_ADDR_i = '0, RS2_ADDR_i = '0;
    logic [31:0] req0_data_i = '0, req1_data_i = '0;
    logic        req0_ready_o, req1_ready_o, hazard_o, wr_en_o;
    logic [4:0]  RD_ADDR_o;
    logic [31:0] data_o;
    int          checks = 0, errors = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid_i), .req0_rd_i(req0_rd_i), .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_rd_i(req1_rd_i), .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .RS1_ADDR_i(RS1_ADDR_i), .RS2_ADDR_i(RS2_ADDR_i), .hazard_o(hazard_o),
        .wr_en_o(wr_en_o), .RD_ADDR_o(RD_ADDR_o), .data_o(data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_wr_en", wr_en_o, 0);
        chk("rst_rd", RD_ADDR_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_hazard", hazard_o, 0);
        rst = 1'b0;

        req0_valid_i = 1'b1; req0_rd_i = 5'd5; req0_data_i = 32'hDEAD_BEEF;
        #1;
        chk("single_ready0", req0_ready_o, 1);
        chk("single_ready1", req1_ready_o, 0);
        step();
        req0_valid_i = 1'b0;
        chk("single_wr_en", wr_en_o, 1);
        chk("single_rd", RD_ADDR_o, 5);
        chk("single_data", data_o, 32'hDEAD_BEEF);

        req1_valid_i = 1'b1; req1_rd_i = 5'd0; req1_data_i = 32'h1234;
        #1;
        chk("x0_ready1", req1_ready_o, 1);
        step();
        req1_valid_i = 1'b0;
        chk("x0_wr_en", wr_en_o, 0);

        req0_valid_i = 1'b1; req0_rd_i = 5'd1; req0_data_i = 32'h101;
        req1_valid_i = 1'b1; req1_rd_i = 5'd2; req1_data_i = 32'h102;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ready0", req0_ready_o, (i % 2 == 0) ? 1 : 0);
            chk("cont_ready1", req1_ready_o, (i % 2 == 1) ? 1 : 0);
            step();
            if (i == 0) begin req0_rd_i = 5'd3; req0_data_i = 32'h103; end
            if (i == 1) begin req1_rd_i = 5'd4; req1_data_i = 32'h104; end
            if (i == 3) begin req0_valid_i = 1'b0; req1_valid_i = 1'b0; end
            chk("cont_wr_en", wr_en_o, 1);
            chk("cont_rd", RD_ADDR_o, i + 1);
            chk("cont_data", data_o, 32'h101 + i);
        end
        step();
        chk("idle_wr_en", wr_en_o, 0);
        chk("idle_rd_hold", RD_ADDR_o, 4);
        chk("idle_data_hold", data_o, 32'h104);

        issue_valid_i = 1'b1; issue_rd_i = 5'd7; RS1_ADDR_i = 5'd7;
        #1;
        chk("sb_pre_hazard", hazard_o, 0);
        step();
        issue_valid_i = 1'b0;
        chk("sb_hazard_set", hazard_o, 1);
        req0_valid_i = 1'b1; req0_rd_i = 5'd7; req0_data_i = 32'h77;
        step();
        req0_valid_i = 1'b0;
        chk("sb_wr_en", wr_en_o, 1);
        chk("sb_rd", RD_ADDR_o, 7);
        chk("sb_hazard_inflight", hazard_o, 1);
        step();
        chk("sb_hazard_clear", hazard_o, 0);

        RS1_ADDR_i = 5'd0; RS2_ADDR_i = 5'd9;
        issue_valid_i = 1'b1; issue_rd_i = 5'd9;
        step();
        issue_valid_i = 1'b0;
        chk("col_hazard_set", hazard_o, 1);
        req0_valid_i = 1'b1; req0_rd_i = 5'd9; req0_data_i = 32'h99;
        step();
        req0_valid_i = 1'b0;
        chk("col_wr_en", wr_en_o, 1);
        chk("col_rd", RD_ADDR_o, 9);
        issue_valid_i = 1'b1; issue_rd_i = 5'd9;
        step();
        issue_valid_i = 1'b0;
        chk("col_hazard_kept", hazard_o, 1);
        step();
        chk("col_hazard_still", hazard_o, 1);

        req0_valid_i = 1'b1; req0_rd_i = 5'd10; req0_data_i = 32'hA0;
        step();
        chk("mid_wr_en", wr_en_o, 1);
        req1_valid_i = 1'b1; req1_rd_i = 5'd11; req1_data_i = 32'hB0;
        #1;
        chk("mid_ready1", req1_ready_o, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", wr_en_o, 0);
        chk("mid_rst_rd", RD_ADDR_o, 0);
        chk("mid_rst_hazard", hazard_o, 0);
        chk("mid_rst_ready0", req0_ready_o, 1);
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", req0_ready_o, 1);
        step();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        chk("post_rst_rd", RD_ADDR_o, 10);
        chk("post_rst_data", data_o, 32'hA0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
